// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg: shared state enum, width helpers and range limits for the adder sweep checker
package adder_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int W_MIN   = 1;
  localparam int W_MAX   = 8;
  localparam int LAT_MAX = 8;
  localparam int DRN_W   = $clog2(LAT_MAX + 1);
  function automatic int vec_w(input int w);
    return 2 * w;
  endfunction
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/adder_chk_delay.sv
// adder_chk_delay: DEPTH-stage shift register for {valid, vec, exact}; pass-through at depth 0
module adder_chk_delay #(
  parameter int DEPTH = 0,
  parameter int DW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [DEPTH*DW-1:0] sr_q, sr_d;
    // stage 0 sits in the low bits; the oldest entry falls off the top
    always_comb sr_d = (sr_q << DW) | (DEPTH*DW)'(d);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= '0;
      else sr_q <= sr_d;
    assign q = sr_q[DEPTH*DW-1 -: DW];
  end
endmodule

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: exhaustive operand sweep and sum checker for a W-bit adder with DUT_LAT latency.
// Define ADDER_CHK_MAXERR_EN to add the max_err port and error-magnitude tracking.
module adder_sweep_checker
  import adder_chk_pkg::*;
#(
  parameter int W       = 2,
  parameter int DUT_LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dut_a,
  output logic [W-1:0] dut_b,
  input  logic [W:0]   dut_y,
  output logic [2*W:0] mism_cnt,
  output logic         first_fail_vld,
  output logic [2*W-1:0] first_fail_vec
`ifdef ADDER_CHK_MAXERR_EN
  ,
  output logic [W:0]   max_err
`endif
);
  localparam int VW = vec_w(W);
  localparam int CW = cnt_w(W);
  localparam int DW = 1 + VW + W + 1;

  state_t            state_q, state_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic [CW-1:0]     mism_q, mism_d;
  logic              ffv_q, ffv_d;
  logic [VW-1:0]     ffvec_q, ffvec_d;
  logic [W:0]        exact, dl_exact;
  logic [VW-1:0]     dl_vec;
  logic              dl_vld, mis, clr;

  assign dut_a = vec_q[W-1:0];
  assign dut_b = vec_q[VW-1:W];
  assign exact = {1'b0, dut_a} + {1'b0, dut_b};

  adder_chk_delay #(.DEPTH(DUT_LAT), .DW(DW)) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({state_q == RUN, vec_q, exact}),
    .q    ({dl_vld, dl_vec, dl_exact})
  );

  assign mis = dl_vld && (dut_y != dl_exact);
  assign clr = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    drn_d   = drn_q;
    mism_d  = clr ? '0 : mism_q + CW'(mis);
    ffv_d   = !clr && (ffv_q || mis);
    ffvec_d = clr ? '0 : (mis && !ffv_q) ? dl_vec : ffvec_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        vec_d   = '0;
      end
      RUN: if (vec_q == '1) begin
        state_d = (DUT_LAT == 0) ? DONE : DRAIN;
        drn_d   = DRN_W'(DUT_LAT - 1);
      end else vec_d = vec_q + 1'b1;
      DRAIN: if (drn_q == '0) state_d = DONE;
             else drn_d = drn_q - 1'b1;
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      drn_q   <= '0;
      mism_q  <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drn_q   <= drn_d;
      mism_q  <= mism_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end

  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = state_q == DONE;
  assign mism_cnt       = mism_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;

`ifdef ADDER_CHK_MAXERR_EN
  logic [W+1:0] diff;
  logic [W:0]   err, maxe_q, maxe_d;
  // the magnitude of a W+2-bit difference of two W+1-bit values always fits W+1 bits
  assign diff = {1'b0, dut_y} - {1'b0, dl_exact};
  assign err  = (W+1)'(diff[W+1] ? -diff : diff);
  always_comb maxe_d = clr ? '0 : (dl_vld && err > maxe_q) ? err : maxe_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) maxe_q <= '0;
    else maxe_q <= maxe_d;
  assign max_err = maxe_q;
`endif
endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb_adder_sweep_checker: directed checks of the sweep checker across widths, latencies and DUT models.
module tb_adder_sweep_checker;
  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, startx = 1'b0, mode = 1'b0;
  int n_cmp = 0, n_bad = 0;

  logic [1:0] a0, b0; logic [2:0] y0; logic [4:0] mism0; logic [3:0] ffvec0; logic [2:0] maxe0;
  logic busy0, done0, ffv0;
  logic [2:0] a1, b1; logic [3:0] y1; logic [6:0] mism1; logic [5:0] ffvec1; logic [3:0] maxe1;
  logic busy1, done1, ffv1;
  logic [1:0] a2, b2; logic [2:0] y2, p2; logic [4:0] mism2; logic [3:0] ffvec2; logic [2:0] maxe2;
  logic busy2, done2, ffv2;
  logic [1:0] a3, b3; logic [2:0] y3, p3; logic [4:0] mism3; logic [3:0] ffvec3; logic [2:0] maxe3;
  logic busy3, done3, ffv3;

  always #5 clk = ~clk;

  assign y0 = mode ? {1'b0, a0 | b0} : {1'b0, a0} + {1'b0, b0};
  always @(posedge clk) begin
    y1 <= '0;
    p2 <= {1'b0, a2} + {1'b0, b2};
    y2 <= p2;
    p3 <= {1'b0, a3} + {1'b0, b3};
    y3 <= p3;
  end

  adder_sweep_checker #(.W(2), .DUT_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .dut_a(a0), .dut_b(b0), .dut_y(y0), .mism_cnt(mism0),
    .first_fail_vld(ffv0), .first_fail_vec(ffvec0)
`ifdef ADDER_CHK_MAXERR_EN
    , .max_err(maxe0)
`endif
  );
  adder_sweep_checker #(.W(3), .DUT_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(startx), .busy(busy1), .done(done1),
    .dut_a(a1), .dut_b(b1), .dut_y(y1), .mism_cnt(mism1),
    .first_fail_vld(ffv1), .first_fail_vec(ffvec1)
`ifdef ADDER_CHK_MAXERR_EN
    , .max_err(maxe1)
`endif
  );
  adder_sweep_checker #(.W(2), .DUT_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(startx), .busy(busy2), .done(done2),
    .dut_a(a2), .dut_b(b2), .dut_y(y2), .mism_cnt(mism2),
    .first_fail_vld(ffv2), .first_fail_vec(ffvec2)
`ifdef ADDER_CHK_MAXERR_EN
    , .max_err(maxe2)
`endif
  );
  adder_sweep_checker #(.W(2), .DUT_LAT(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(startx), .busy(busy3), .done(done3),
    .dut_a(a3), .dut_b(b3), .dut_y(y3), .mism_cnt(mism3),
    .first_fail_vld(ffv3), .first_fail_vec(ffvec3)
`ifdef ADDER_CHK_MAXERR_EN
    , .max_err(maxe3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    go(2);
    chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_mism", mism0, 0);
    chk("rst_ffv", ffv0, 0); chk("rst_ffvec", ffvec0, 0); chk("rst_a", a0, 0); chk("rst_b", b0, 0);
    rst_n = 1'b1; go(1);
    // exact adder, single start pulse
    start0 = 1'b1; go(1); start0 = 1'b0;
    chk("s1_busy_e0", busy0, 1); chk("s1_a_e0", a0, 0); chk("s1_b_e0", b0, 0);
    go(5); chk("s1_a_e5", a0, 1); chk("s1_b_e5", b0, 1);
    go(10); chk("s1_done_e15", done0, 0); chk("s1_busy_e15", busy0, 1);
    chk("s1_a_e15", a0, 3); chk("s1_b_e15", b0, 3);
    go(1); chk("s1_done_e16", done0, 1); chk("s1_busy_e16", busy0, 0);
    chk("s1_mism", mism0, 0); chk("s1_ffv", ffv0, 0);
`ifdef ADDER_CHK_MAXERR_EN
    chk("s1_maxerr", maxe0, 0);
`endif
    go(1); chk("s1_done_e17", done0, 0); chk("s1_busy_e17", busy0, 0);
    // a|b DUT
    mode = 1'b1; start0 = 1'b1; go(1); start0 = 1'b0;
    go(5); chk("s2_mism_e5", mism0, 0); chk("s2_ffv_e5", ffv0, 0);
    go(2); chk("s2_mism_e7", mism0, 1); chk("s2_ffv_e7", ffv0, 1); chk("s2_ffvec_e7", ffvec0, 5);
    go(9); chk("s2_done", done0, 1); chk("s2_mism", mism0, 7); chk("s2_ffvec", ffvec0, 5);
`ifdef ADDER_CHK_MAXERR_EN
    chk("s2_maxerr", maxe0, 3);
`endif
    go(3); chk("s2_hold_mism", mism0, 7); chk("s2_hold_ffv", ffv0, 1);
    // start held high: back-to-back sweeps
    start0 = 1'b1; go(1);
    chk("s3_clr_mism", mism0, 0); chk("s3_clr_ffv", ffv0, 0); chk("s3_busy", busy0, 1);
    go(16); chk("s3_done_e16", done0, 1); chk("s3_mism_e16", mism0, 7);
    go(1); chk("s3_done_e17", done0, 0); chk("s3_busy_e17", busy0, 0); chk("s3_idle_mism", mism0, 7);
    go(1); chk("s3_busy_e18", busy0, 1); chk("s3_mism_e18", mism0, 0); chk("s3_ffv_e18", ffv0, 0);
    chk("s3_a_e18", a0, 0);
    go(15); chk("s3_done_e33", done0, 0);
    go(1); chk("s3_done_e34", done0, 1); chk("s3_mism_e34", mism0, 7); chk("s3_ffvec_e34", ffvec0, 5);
    start0 = 1'b0; go(2);
    // reset in the middle of a sweep
    start0 = 1'b1; go(1); start0 = 1'b0;
    go(8); chk("s4_mism_e8", mism0, 2); chk("s4_a_e8", a0, 0); chk("s4_b_e8", b0, 2);
    rst_n = 1'b0; #1;
    chk("s4_rst_busy", busy0, 0); chk("s4_rst_mism", mism0, 0); chk("s4_rst_ffv", ffv0, 0);
    chk("s4_rst_ffvec", ffvec0, 0); chk("s4_rst_b", b0, 0); chk("s4_rst_done", done0, 0);
    go(1); rst_n = 1'b1; go(1); chk("s4_idle_busy", busy0, 0);
    start0 = 1'b1; go(1); start0 = 1'b0;
    go(16); chk("s5_done", done0, 1); chk("s5_mism", mism0, 7); chk("s5_ffvec", ffvec0, 5);
    chk("s5_ffv", ffv0, 1);
    mode = 1'b0;
    // latency variants: W=3 constant-zero, and a 2-cycle exact adder at latency 2 and 1
    startx = 1'b1; go(1); startx = 1'b0;
    go(16); chk("l1_done_e16", done3, 0); chk("l2_done_e16", done2, 0);
    go(1); chk("l1_done_e17", done3, 1); chk("l1_mism_nz", mism3 != 0, 1);
    go(1); chk("l2_done_e18", done2, 1); chk("l2_mism", mism2, 0); chk("l2_ffv", ffv2, 0);
    go(46); chk("w3_done_e64", done1, 0); chk("w3_busy_e64", busy1, 1);
    go(1); chk("w3_done_e65", done1, 1); chk("w3_mism", mism1, 63);
    chk("w3_ffvec", ffvec1, 1); chk("w3_ffv", ffv1, 1);
`ifdef ADDER_CHK_MAXERR_EN
    chk("w3_maxerr", maxe1, 14);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
